// File: rtl/hs32_writeback.sv
// hs32 writeback stage: merges buffered execute results and unstalled load results onto
// the register file's single write port, and flags registers with writes still in flight.
module hs32_writeback #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [3:0]  ex_addr_i,
    input  logic        ex_bank_i,
    input  logic [31:0] ex_data_i,

    input  logic        ld_valid_i,
    input  logic [3:0]  ld_addr_i,
    input  logic        ld_bank_i,
    input  logic [31:0] ld_data_i,

    output logic [3:0]  wp1_addr_o,
    output logic [31:0] wp1_data_o,
    output logic        wp1_we1_o,
    output logic        wp1_we2_o,

    input  logic        q_banksel_i,
    input  logic [3:0]  q1_addr_i,
    input  logic [3:0]  q2_addr_i,
    output logic        q1_hazard_o,
    output logic        q2_hazard_o,

    output logic        idle_o
);

    typedef struct packed {
        logic [3:0]  addr;
        logic        bank;
        logic [31:0] data;
    } wb_entry_t;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_entry_t          fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         out_addr_q, out_addr_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               we1_q, we1_d;
    logic               we2_q, we2_d;

    logic               push_c;
    logic               pop_c;
    wb_entry_t          head_c;
    wb_entry_t          ex_entry_c;
    logic [DEPTH-1:0]   entry_valid_c;

    // Same-bank match; the 8-entry bank only decodes the low three address bits.
    function automatic logic addr_match(input logic [3:0] src_addr, input logic src_bank,
                                        input logic [3:0] q_addr, input logic q_bank);
        logic hit;
        hit = 1'b0;
        if (src_bank == q_bank) begin
            if (q_bank) hit = (src_addr[2:0] == q_addr[2:0]);
            else        hit = (src_addr == q_addr);
        end
        return hit;
    endfunction

    assign ex_ready_o = !reset && (count_q < FULL_CNT);
    assign push_c     = ex_valid_i && ex_ready_o;
    assign pop_c      = !ld_valid_i && (count_q != '0);
    assign head_c     = fifo_q[rd_ptr_q];
    assign ex_entry_c = '{addr: ex_addr_i, bank: ex_bank_i, data: ex_data_i};

    assign wp1_addr_o = out_addr_q;
    assign wp1_data_o = out_data_q;
    assign wp1_we1_o  = we1_q;
    assign wp1_we2_o  = we2_q;
    assign idle_o     = (count_q == '0) && !we1_q && !we2_q && !ld_valid_i;

    // Next-state: FIFO bookkeeping and write-port arbitration (loads strictly first).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        we1_d      = 1'b0;
        we2_d      = 1'b0;

        if (push_c) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);

        if (ld_valid_i) begin
            out_addr_d = ld_addr_i;
            out_data_d = ld_data_i;
            we1_d      = !ld_bank_i;
            we2_d      = ld_bank_i;
        end else if (pop_c) begin
            out_addr_d = head_c.addr;
            out_data_d = head_c.data;
            we1_d      = !head_c.bank;
            we2_d      = head_c.bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            we1_q      <= 1'b0;
            we2_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            we1_q      <= we1_d;
            we2_q      <= we2_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= ex_entry_c;
    end

    always_comb begin
        entry_valid_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs = PTR_W'(i) - rd_ptr_q;
            entry_valid_c[i] = (CNT_W'(offs) < count_q);
        end
    end

    // Pending writes: queued entries, the write in flight, an arriving load, an accepted push.
    always_comb begin
        q1_hazard_o = 1'b0;
        q2_hazard_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid_c[i]) begin
                q1_hazard_o = q1_hazard_o | addr_match(fifo_q[i].addr, fifo_q[i].bank, q1_addr_i, q_banksel_i);
                q2_hazard_o = q2_hazard_o | addr_match(fifo_q[i].addr, fifo_q[i].bank, q2_addr_i, q_banksel_i);
            end
        end
        if (we1_q || we2_q) begin
            q1_hazard_o = q1_hazard_o | addr_match(out_addr_q, we2_q, q1_addr_i, q_banksel_i);
            q2_hazard_o = q2_hazard_o | addr_match(out_addr_q, we2_q, q2_addr_i, q_banksel_i);
        end
        if (ld_valid_i) begin
            q1_hazard_o = q1_hazard_o | addr_match(ld_addr_i, ld_bank_i, q1_addr_i, q_banksel_i);
            q2_hazard_o = q2_hazard_o | addr_match(ld_addr_i, ld_bank_i, q2_addr_i, q_banksel_i);
        end
        if (push_c) begin
            q1_hazard_o = q1_hazard_o | addr_match(ex_addr_i, ex_bank_i, q1_addr_i, q_banksel_i);
            q2_hazard_o = q2_hazard_o | addr_match(ex_addr_i, ex_bank_i, q2_addr_i, q_banksel_i);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);
    a_we_onehot:   assert property (@(posedge clk) !(we1_q && we2_q));

endmodule

// File: tb/tb_hs32_writeback.sv
// Directed bench for hs32_writeback: a DEPTH=2 and a DEPTH=4 instance share all inputs.
module tb_hs32_writeback;

    localparam logic [31:0] LD_PAT = 32'h5A5A_5A5A;

    logic        clk;
    logic        reset;
    logic        ex_valid, ex_bank, ld_valid, ld_bank, q_banksel;
    logic [3:0]  ex_addr, ld_addr, q1_addr, q2_addr;
    logic [31:0] ex_data, ld_data;

    logic        ready2, we1_2, we2_2, h1_2, h2_2, idle2;
    logic [3:0]  addr2;
    logic [31:0] data2;
    logic        ready4, we1_4, we2_4, h1_4, h2_4, idle4;
    logic [3:0]  addr4;
    logic [31:0] data4;

    int errors;
    int checks;

    hs32_writeback #(.DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid), .ex_ready_o(ready2), .ex_addr_i(ex_addr), .ex_bank_i(ex_bank), .ex_data_i(ex_data),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_bank_i(ld_bank), .ld_data_i(ld_data),
        .wp1_addr_o(addr2), .wp1_data_o(data2), .wp1_we1_o(we1_2), .wp1_we2_o(we2_2),
        .q_banksel_i(q_banksel), .q1_addr_i(q1_addr), .q2_addr_i(q2_addr),
        .q1_hazard_o(h1_2), .q2_hazard_o(h2_2), .idle_o(idle2)
    );

    hs32_writeback #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid), .ex_ready_o(ready4), .ex_addr_i(ex_addr), .ex_bank_i(ex_bank), .ex_data_i(ex_data),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_bank_i(ld_bank), .ld_data_i(ld_data),
        .wp1_addr_o(addr4), .wp1_data_o(data4), .wp1_we1_o(we1_4), .wp1_we2_o(we2_4),
        .q_banksel_i(q_banksel), .q1_addr_i(q1_addr), .q2_addr_i(q2_addr),
        .q1_hazard_o(h1_4), .q2_hazard_o(h2_4), .idle_o(idle4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 1'b0; ex_addr = 4'h0; ex_bank = 1'b0; ex_data = 32'h0;
        ld_valid = 1'b0; ld_addr = 4'h0; ld_bank = 1'b0; ld_data = 32'h0;
        q_banksel = 1'b0; q1_addr = 4'h0; q2_addr = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", ready2); end
        reset = 1'b0;
        #1;
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", ready2); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b want 1", ready4); end
        checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle2); end
        checks++; if ({we1_2, we2_2} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", {we1_2, we2_2}); end
        checks++; if (addr2 !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr2); end
        checks++; if (data2 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data2); end
        tick();
    endtask

    task automatic test_single_exec();
        // cycle 1: push {5, bank 0, DEADBEEF}
        ex_valid = 1'b1; ex_addr = 4'h5; ex_bank = 1'b0; ex_data = 32'hDEAD_BEEF;
        q_banksel = 1'b0; q1_addr = 4'h5; q2_addr = 4'h6;
        #1;
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL single_haz_c1: got %b want 1", h1_2); end
        checks++; if (h2_2 !== 1'b0) begin errors++; $display("FAIL single_haz2_c1: got %b want 0", h2_2); end
        checks++; if (h1_4 !== 1'b1) begin errors++; $display("FAIL single_haz4_c1: got %b want 1", h1_4); end
        tick();
        ex_valid = 1'b0;
        #1;
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL single_haz_c2: got %b want 1", h1_2); end
        checks++; if (we1_2 !== 1'b0) begin errors++; $display("FAIL single_we_c2: got %b want 0", we1_2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2} !== 2'b10) begin errors++; $display("FAIL single_we_c3: got %b want 10", {we1_2, we2_2}); end
        checks++; if (addr2 !== 4'h5) begin errors++; $display("FAIL single_addr: got %h want 5", addr2); end
        checks++; if (data2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", data2); end
        checks++; if (data4 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data4: got %h want deadbeef", data4); end
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL single_haz_c3: got %b want 1", h1_2); end
        checks++; if (idle2 !== 1'b0) begin errors++; $display("FAIL single_idle_c3: got %b want 0", idle2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2} !== 2'b00) begin errors++; $display("FAIL single_we_c4: got %b want 00", {we1_2, we2_2}); end
        checks++; if (h1_2 !== 1'b0) begin errors++; $display("FAIL single_haz_c4: got %b want 0", h1_2); end
        checks++; if (addr2 !== 4'h5) begin errors++; $display("FAIL single_addr_hold: got %h want 5", addr2); end
        checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL single_idle_c4: got %b want 1", idle2); end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_priority();
        // cycle 1: push A
        ex_valid = 1'b1; ex_addr = 4'h3; ex_bank = 1'b0; ex_data = 32'h1111_1111;
        tick();
        // cycle 2: push B, load L1 starts blocking the port
        ex_addr = 4'h4; ex_bank = 1'b1; ex_data = 32'h2222_2222;
        ld_valid = 1'b1; ld_addr = 4'h7; ld_bank = 1'b0; ld_data = 32'hA000_0001;
        tick();
        // cycle 3: L2, L1 written
        ex_valid = 1'b0;
        ld_addr = 4'h8; ld_bank = 1'b0; ld_data = 32'hA000_0002;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL lp_ready_c3: got %b want 0", ready2); end
        checks++; if ({we1_2, we2_2, addr2} !== {2'b10, 4'h7}) begin errors++; $display("FAIL lp_l1: got we=%b addr=%h want we=10 addr=7", {we1_2, we2_2}, addr2); end
        checks++; if (data2 !== 32'hA000_0001) begin errors++; $display("FAIL lp_l1_data: got %h want a0000001", data2); end
        tick();
        // cycle 4: L3 (bank 1), L2 written
        ld_addr = 4'h2; ld_bank = 1'b1; ld_data = 32'hA000_0003;
        q_banksel = 1'b0; q1_addr = 4'h3; q2_addr = 4'h8;
        #1;
        checks++; if ({we1_2, we2_2, addr2} !== {2'b10, 4'h8}) begin errors++; $display("FAIL lp_l2: got we=%b addr=%h want we=10 addr=8", {we1_2, we2_2}, addr2); end
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL lp_ready_c4: got %b want 0", ready2); end
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL lp_haz_fifo: got %b want 1", h1_2); end
        checks++; if (h2_4 !== 1'b1) begin errors++; $display("FAIL lp_haz_out: got %b want 1", h2_4); end
        tick();
        // cycle 5: loads off, L3 written, FIFO still full during its first pop
        clear_inputs();
        #1;
        checks++; if ({we1_2, we2_2, addr2} !== {2'b01, 4'h2}) begin errors++; $display("FAIL lp_l3: got we=%b addr=%h want we=01 addr=2", {we1_2, we2_2}, addr2); end
        checks++; if (data2 !== 32'hA000_0003) begin errors++; $display("FAIL lp_l3_data: got %h want a0000003", data2); end
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL lp_ready_c5: got %b want 0", ready2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2, addr2} !== {2'b10, 4'h3}) begin errors++; $display("FAIL lp_a: got we=%b addr=%h want we=10 addr=3", {we1_2, we2_2}, addr2); end
        checks++; if (data2 !== 32'h1111_1111) begin errors++; $display("FAIL lp_a_data: got %h want 11111111", data2); end
        checks++; if (data4 !== 32'h1111_1111) begin errors++; $display("FAIL lp_a_data4: got %h want 11111111", data4); end
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL lp_ready_c6: got %b want 1", ready2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2, addr2} !== {2'b01, 4'h4}) begin errors++; $display("FAIL lp_b: got we=%b addr=%h want we=01 addr=4", {we1_2, we2_2}, addr2); end
        checks++; if (data2 !== 32'h2222_2222) begin errors++; $display("FAIL lp_b_data: got %h want 22222222", data2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2, idle2} !== 3'b001) begin errors++; $display("FAIL lp_drained: got we=%b idle=%b want we=00 idle=1", {we1_2, we2_2}, idle2); end
        tick();
    endtask

    task automatic test_bank1_alias();
        ld_valid = 1'b1; ld_addr = 4'hB; ld_bank = 1'b1; ld_data = 32'hCAFE_F00D;
        q_banksel = 1'b1; q1_addr = 4'h3; q2_addr = 4'h4;
        #1;
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL b1_haz_ld: got %b want 1", h1_2); end
        checks++; if (h2_2 !== 1'b0) begin errors++; $display("FAIL b1_haz_other: got %b want 0", h2_2); end
        tick();
        ld_valid = 1'b0;
        #1;
        checks++; if ({we1_2, we2_2, addr2} !== {2'b01, 4'hB}) begin errors++; $display("FAIL b1_write: got we=%b addr=%h want we=01 addr=b", {we1_2, we2_2}, addr2); end
        checks++; if (data2 !== 32'hCAFE_F00D) begin errors++; $display("FAIL b1_data: got %h want cafef00d", data2); end
        checks++; if (h1_2 !== 1'b1) begin errors++; $display("FAIL b1_haz_out: got %b want 1", h1_2); end
        q_banksel = 1'b0; q1_addr = 4'hB;
        #1;
        checks++; if (h1_2 !== 1'b0) begin errors++; $display("FAIL b1_haz_bank0: got %b want 0", h1_2); end
        tick();
        #1;
        checks++; if ({we1_2, we2_2} !== 2'b00) begin errors++; $display("FAIL b1_we_clear: got %b want 00", {we1_2, we2_2}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_full_wrap();
        int sent;
        int seen;
        logic exp_bank;
        sent = 0;
        seen = 0;
        for (int cyc = 1; cyc <= 40 && seen < 8; cyc++) begin
            ld_valid = (cyc <= 5); ld_addr = 4'hF; ld_bank = 1'b0; ld_data = LD_PAT;
            ex_valid = (sent < 8); ex_addr = 4'(sent); ex_bank = sent[0]; ex_data = 32'hE000_0000 | 32'(sent);
            #1;
            if (cyc == 5 || cyc == 6) begin
                checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL fw_ready_full c%0d: got %b want 0", cyc, ready4); end
            end
            if (cyc == 7) begin
                checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL fw_ready_rise: got %b want 1", ready4); end
            end
            if ((we1_4 || we2_4) && data4 !== LD_PAT) begin
                exp_bank = seen[0];
                checks++;
                if (addr4 !== 4'(seen) || data4 !== (32'hE000_0000 | 32'(seen)) || we2_4 !== exp_bank || we1_4 !== !exp_bank) begin
                    errors++;
                    $display("FAIL fw_order #%0d: got addr=%h data=%h we=%b%b want addr=%h data=%h bank=%b",
                             seen, addr4, data4, we1_4, we2_4, 4'(seen), 32'hE000_0000 | 32'(seen), exp_bank);
                end
                seen++;
            end
            if (ex_valid && ready4) sent++;
            tick();
        end
        checks++; if (seen !== 8) begin errors++; $display("FAIL fw_count: got %0d writes want 8", seen); end
        clear_inputs();
        #1;
        checks++; if ({we1_4, we2_4, idle4} !== 3'b001) begin errors++; $display("FAIL fw_no_extra: got we=%b%b idle=%b want 00 1", we1_4, we2_4, idle4); end
        tick();
    endtask

    task automatic test_reset_midstream();
        ex_valid = 1'b1; ex_addr = 4'h1; ex_bank = 1'b0; ex_data = 32'h0000_0A01;
        tick();
        ex_addr = 4'h2; ex_data = 32'h0000_0A02;
        ld_valid = 1'b1; ld_addr = 4'h9; ld_bank = 1'b0; ld_data = 32'h0000_0B09;
        tick();
        // cycle 3: two entries queued, load write in flight; reset with fresh inputs that must drop
        reset = 1'b1;
        ex_addr = 4'h3; ex_data = 32'h0000_0A03;
        ld_addr = 4'hA; ld_data = 32'h0000_0B0A;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset: got %b want 0", ready2); end
        checks++; if (we1_2 !== 1'b1) begin errors++; $display("FAIL rm_we_before: got %b want 1", we1_2); end
        tick();
        reset = 1'b0;
        clear_inputs();
        q_banksel = 1'b0; q1_addr = 4'h1;
        #1;
        checks++; if ({we1_2, we2_2, we1_4, we2_4} !== 4'b0000) begin errors++; $display("FAIL rm_we_after: got %b want 0000", {we1_2, we2_2, we1_4, we2_4}); end
        checks++; if ({addr2, data2} !== 36'h0) begin errors++; $display("FAIL rm_out_clear: got addr=%h data=%h want 0", addr2, data2); end
        checks++; if ({idle2, idle4, ready2} !== 3'b111) begin errors++; $display("FAIL rm_idle_ready: got %b want 111", {idle2, idle4, ready2}); end
        checks++; if (h1_2 !== 1'b0) begin errors++; $display("FAIL rm_haz: got %b want 0", h1_2); end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            checks++; if ({we1_2, we2_2, we1_4, we2_4} !== 4'b0000) begin errors++; $display("FAIL rm_no_write c%0d: got %b want 0000", k, {we1_2, we2_2, we1_4, we2_4}); end
        end
        checks++; if ({idle2, idle4} !== 2'b11) begin errors++; $display("FAIL rm_idle_end: got %b want 11", {idle2, idle4}); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_exec();
        test_load_priority();
        test_bank1_alias();
        test_full_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
